ram_march_bist: RTL and testbench

- Initiator-side controller that drives the single-port RAM port (`we`, `addr`, `data`) and checks its read output (`val`).
- On `start` it runs a three-phase march test over every address and compares each read against the expected value.
- It reports pass/fail, the first failing address/data, and a mismatch count.
- It sits beside the RAM and replaces the hand-written write/read stimulus currently used to exercise the RAM.

---
 rtl/ram_march_bist.sv | 139 +++++++++++++
 tb/tb_ram_march_bist.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// Three-phase march BIST for a single-port RAM:
// W0 writes P, R0W1 reads P and writes ~P, R1 reads ~P in descending order.
module ram_march_bist #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pattern_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_val_i
);
    typedef enum logic [2:0] {IDLE, W0, R0W1, R1, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    state_t            state_q;
    logic [DATA_W-1:0] pat_q;
    logic              busy_q, done_q, pass_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    // Read issued at the previous edge: its data is on ram_val_i this cycle.
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_exp_q;
    logic              mismatch;

    assign mismatch = rd_vld_q && (ram_val_i != rd_exp_q);

    always_comb begin
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (err_q == '0) begin
                fail_addr_d = rd_addr_q;
                fail_data_d = ram_val_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_exp_q    <= '0;
        end else begin
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            unique case (state_q)
                IDLE: if (start_i) begin
                    pat_q       <= pattern_i;
                    err_q       <= '0;
                    fail_addr_q <= '0;
                    fail_data_q <= '0;
                    pass_q      <= 1'b0;
                    busy_q      <= 1'b1;
                    we_q        <= 1'b1;
                    addr_q      <= '0;
                    data_q      <= pattern_i;
                    state_q     <= W0;
                end
                W0: if (addr_q == ADDR_MAX) begin
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    state_q <= R0W1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
                R0W1: if (!we_q) begin
                    rd_vld_q  <= 1'b1;
                    rd_addr_q <= addr_q;
                    rd_exp_q  <= pat_q;
                    we_q      <= 1'b1;
                    data_q    <= ~pat_q;
                end else begin
                    we_q <= 1'b0;
                    // R1 starts at the top address, so the counter stays put.
                    if (addr_q == ADDR_MAX) state_q <= R1;
                    else                    addr_q  <= addr_q + 1'b1;
                end
                R1: begin
                    rd_vld_q  <= 1'b1;
                    rd_addr_q <= addr_q;
                    rd_exp_q  <= ~pat_q;
                    if (addr_q == '0) state_q <= DRAIN;
                    else              addr_q  <= addr_q - 1'b1;
                end
                DRAIN: begin
                    pass_q  <= (err_q == '0) && !mismatch;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_data_o  = data_q;
endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: faulty-RAM model, march reference model, table + random runs.
module tb_ram_march_bist;
    localparam int DEPTH = 64;

    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       busy, done, pass, ram_we;
    logic [7:0] err_count, ram_data, fail_data, ram_val;
    logic [5:0] fail_addr, ram_addr;
    logic       busy2, done2, pass2, ram_we2;
    logic [3:0] err2;
    logic [5:0] fail_addr2, ram_addr2;
    logic [7:0] fail_data2, ram_data2;
    logic [7:0] ram_val2 = 8'hFF;

    int nvec = 0, nmis = 0;

    // Fault config of the RAM model: 0 none, 1 stuck-at-1 mask, 2 write-dead cell reading fparam.
    int         f_mode = 0, f_addr = 0;
    logic [7:0] f_param = 8'h00;
    logic [7:0] mem [DEPTH];

    always #5 clk = ~clk;

    ram_march_bist #(.ADDR_W(6), .DATA_W(8), .ERR_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pattern_i(pattern),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
        .fail_addr_o(fail_addr), .fail_data_o(fail_data),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_val_i(ram_val));

    ram_march_bist #(.ADDR_W(6), .DATA_W(8), .ERR_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .pattern_i(8'h00),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
        .fail_addr_o(fail_addr2), .fail_data_o(fail_data2),
        .ram_we_o(ram_we2), .ram_addr_o(ram_addr2), .ram_data_o(ram_data2), .ram_val_i(ram_val2));

    function automatic logic [7:0] frd(input logic [7:0] s, input int a, input int mode,
                                       input int fa, input logic [7:0] fp);
        if (mode == 1 && a == fa) return s | fp;
        if (mode == 2 && a == fa) return fp;
        return s;
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        else        ram_val <= frd(mem[ram_addr], int'(ram_addr), f_mode, f_addr, f_param);
    end

    // March reference: whole-test result from the algorithm, not cycle timing.
    function automatic void model(input logic [7:0] p, input int mode, input int fa,
                                  input logic [7:0] fp, input int emax, output logic ep,
                                  output int ee, output int efa, output logic [7:0] efd);
        logic [7:0] m [DEPTH];
        logic [7:0] v;
        ee = 0; efa = 0; efd = 8'h00;
        for (int a = 0; a < DEPTH; a++) m[a] = p;
        for (int a = 0; a < DEPTH; a++) begin
            v = frd(m[a], a, mode, fa, fp);
            if (v != p) begin
                if (ee == 0) begin efa = a; efd = v; end
                if (ee < emax) ee++;
            end
            m[a] = ~p;
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            v = frd(m[a], a, mode, fa, fp);
            if (v != ~p) begin
                if (ee == 0) begin efa = a; efd = v; end
                if (ee < emax) ee++;
            end
        end
        ep = (ee == 0);
    endfunction

    // Expected RAM port activity in cycle c (cycle 1 follows the start edge); a<0 = don't care.
    function automatic void exp_op(input int c, input logic [7:0] p, output logic we,
                                   output int a, output logic [7:0] d);
        we = 1'b0; a = -1; d = p;
        if (c >= 1 && c <= DEPTH) begin
            we = 1'b1; a = c - 1;
        end else if (c <= 3 * DEPTH) begin
            a = (c - DEPTH - 1) / 2; we = ((c - DEPTH - 1) % 2) == 1; d = ~p;
        end else if (c <= 4 * DEPTH) begin
            a = DEPTH - 1 - (c - 3 * DEPTH - 1);
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] pat;
        int         mode;
        int         faddr;
        logic [7:0] fparam;
        logic       exp_pass;
        int         exp_err;
        int         exp_fa;
        logic [7:0] exp_fd;
    } vec_t;

    // Run one full test; xs pulses start again at cycles 10 and 200.
    task automatic run_test(input string tag, input vec_t v, input bit xs);
        int         op_bad = 0, first_bad = 0, done_cyc = 0, done_cnt = 0;
        logic       we;
        int         a;
        logic [7:0] d;
        f_mode = v.mode; f_addr = v.faddr; f_param = v.fparam;
        @(negedge clk); start = 1'b1; pattern = v.pat;
        @(posedge clk); #1 start = 1'b0; pattern = ~v.pat;
        for (int c = 1; c <= 4 * DEPTH + 6; c++) begin
            if (xs) start = (c == 10 || c == 200);
            exp_op(c, v.pat, we, a, d);
            if (ram_we !== we || (a >= 0 && ram_addr !== a[5:0]) || (we && ram_data !== d)
                || busy !== (c <= 4 * DEPTH + 1)) begin
                op_bad++;
                if (first_bad == 0) first_bad = c;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk($sformatf("%s ops (first bad cycle %0d)", tag, first_bad), op_bad, 0);
        chk({tag, " done_cycle"}, done_cyc, 4 * DEPTH + 2);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " pass"}, pass, v.exp_pass);
        chk({tag, " err_count"}, err_count, v.exp_err);
        chk({tag, " fail_addr"}, fail_addr, v.exp_fa);
        chk({tag, " fail_data"}, fail_data, v.exp_fd);
    endtask

    initial begin
        vec_t tbl [5];
        vec_t rv;
        int   n, cnt_we, cnt_done;
        tbl[0] = '{8'h5A, 0, 0,  8'h00, 1'b1, 0, 0,  8'h00};
        tbl[1] = '{8'h00, 1, 19, 8'h01, 1'b0, 1, 19, 8'h01};
        tbl[2] = '{8'h2B, 2, 4,  8'h2C, 1'b0, 2, 4,  8'h2C};
        tbl[3] = '{8'hFF, 1, 63, 8'h80, 1'b0, 1, 63, 8'h80};
        tbl[4] = '{8'h00, 2, 0,  8'h00, 1'b0, 1, 0,  8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);        chk("rst done", done, 0);
        chk("rst pass", pass, 0);        chk("rst err_count", err_count, 0);
        chk("rst fail_addr", fail_addr, 0); chk("rst fail_data", fail_data, 0);
        chk("rst ram_we", ram_we, 0);    chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_data", ram_data, 0);
        start = 1'b1; pattern = 8'h33;
        @(posedge clk); #1;
        chk("start with rst busy", busy, 0);
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_test($sformatf("tbl%0d", i), tbl[i], 1'b0);

        // Restart attempts mid-test must be ignored.
        run_test("restart", tbl[0], 1'b1);

        for (int i = 0; i < 6; i++) begin
            rv.pat   = 8'($urandom);
            rv.mode  = $urandom_range(0, 2);
            rv.faddr = $urandom_range(0, DEPTH - 1);
            rv.fparam = (rv.mode == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            model(rv.pat, rv.mode, rv.faddr, rv.fparam, 255,
                  rv.exp_pass, rv.exp_err, rv.exp_fa, rv.exp_fd);
            run_test($sformatf("rand%0d", i), rv, 1'b0);
        end

        // Reset mid-test after one mismatch has been counted.
        f_mode = 1; f_addr = 2; f_param = 8'h01;
        @(negedge clk); start = 1'b1; pattern = 8'h00;
        @(posedge clk); #1 start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        chk("pre-rst err_count", err_count, 1);
        chk("pre-rst busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-rst busy", busy, 0);
        chk("post-rst ram_we", ram_we, 0);
        chk("post-rst err_count", err_count, 0);
        cnt_we = 0; cnt_done = 0;
        for (int c = 0; c < 300; c++) begin
            if (ram_we === 1'b1) cnt_we++;
            if (done === 1'b1) cnt_done++;
            @(posedge clk); #1;
        end
        chk("post-rst writes", cnt_we, 0);
        chk("post-rst done pulses", cnt_done, 0);
        run_test("after_rst", tbl[0], 1'b0);

        // Narrow counter saturates against a RAM that always reads 0xFF.
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("sat done seen", done2, 1);
        chk("sat err_count", err2, 15);
        chk("sat fail_addr", fail_addr2, 0);
        chk("sat fail_data", fail_data2, 8'hFF);
        chk("sat pass", pass2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
